// File: rtl/serial_greater_than_finder.sv
// Bit-serial, MSB-first magnitude comparator.
// Two WIDTH-bit operands are captured on an accepted start and walked one bit
// per clock from the MSB. The walk stops at the first differing bit, or after
// the LSB when the operands are equal. Exactly one of gtf/eqf/ltf is then
// reported, together with a single-cycle done pulse.
module serial_greater_than_finder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             busy,
    output logic             done,
    output logic             gtf,
    output logic             eqf,
    output logic             ltf
);

    // cnt counts the bits still to be examined after the current one. It
    // starts at WIDTH-1, so it always fits in $clog2(WIDTH) bits. The walk
    // leaves SHIFT at cnt==0, so cnt never wraps.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             gtf_nxt;
    logic             eqf_nxt;
    logic             ltf_nxt;
    logic             a_msb;
    logic             b_msb;

    // The operands shift left, so the bit currently under test is always
    // the top bit of each shift register.
    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];

    // busy follows the state directly. It therefore drops in the same cycle
    // that done is high.
    assign busy = (state == SHIFT);

    // State and datapath registers. The reset clears everything and
    // discards any compare that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            gtf   <= 1'b0;
            eqf   <= 1'b0;
            ltf   <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            gtf   <= gtf_nxt;
            eqf   <= eqf_nxt;
            ltf   <= ltf_nxt;
        end
    end

    // Next-state and datapath logic. The flags hold by default, and done
    // defaults to 0, so it can only ever be a one-cycle pulse.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        gtf_nxt   = gtf;
        eqf_nxt   = eqf;
        ltf_nxt   = ltf;

        case (state)
            IDLE: begin
                // The done cycle is also an IDLE cycle. This lets a
                // back-to-back start be taken with no gap.
                if (start) begin
                    a_nxt     = i0;
                    b_nxt     = i1;
                    cnt_nxt   = CW'(WIDTH - 1);
                    gtf_nxt   = 1'b0;
                    eqf_nxt   = 1'b0;
                    ltf_nxt   = 1'b0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                // While SHIFT is active, start and the operand inputs are
                // ignored. Only the latched copies in a/b are used.
                if (a_msb != b_msb) begin
                    gtf_nxt   = a_msb;
                    ltf_nxt   = ~a_msb;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    eqf_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    a_nxt   = {a[WIDTH-2:0], 1'b0};
                    b_nxt   = {b[WIDTH-2:0], 1'b0};
                    cnt_nxt = cnt - CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_greater_than_finder.sv
// Self-checking bench for serial_greater_than_finder (WIDTH=8).
// Expected flags come from plain unsigned comparison of the operands latched
// at start. Expected latency is the position of the first differing bit
// counted from the MSB, or WIDTH for equal operands.
module tb_serial_greater_than_finder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         busy;
    logic         done;
    logic         gtf;
    logic         eqf;
    logic         ltf;

    int           checks;
    int           failures;
    logic [W-1:0] ref_a;
    logic [W-1:0] ref_b;

    serial_greater_than_finder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .i0    (i0),
        .i1    (i1),
        .busy  (busy),
        .done  (done),
        .gtf   (gtf),
        .eqf   (eqf),
        .ltf   (ltf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle a little before sampling or
    // driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Number of bits examined: the MSB-relative index of the first difference
    // plus one, or all bits when the operands are equal.
    function automatic int refLatency(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < W; i++) begin
            if (x[W-1-i] != y[W-1-i]) return i + 1;
        end
        return W;
    endfunction

    // Present operands with start for one edge (E0). Then check that the
    // compare is in progress with all flags cleared.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
        i0    = x;
        i1    = y;
        start = 1'b1;
        ref_a = x;
        ref_b = y;
        tick();
        start = 1'b0;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_done", 32'(done), 32'd0);
        checkOutput("start_flags", 32'({gtf, eqf, ltf}), 32'd0);
    endtask

    // Wait, within a bounded number of cycles, for done. Check busy and the
    // flags while waiting, then check latency and result at done. With noise
    // set, the operand inputs are scrambled and start is toggled while busy.
    // Both must have no effect. The task returns in the done cycle with
    // start low.
    task automatic waitDone(input string tag, input bit noise);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        while (k < W + 4) begin
            tick();
            k++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            checkOutput({tag, "_busy_wait"}, 32'(busy), 32'd1);
            checkOutput({tag, "_flags_wait"}, 32'({gtf, eqf, ltf}), 32'd0);
            if (noise) begin
                i0    = W'($urandom);
                i1    = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        if (!got) begin
            checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
        end else begin
            checkOutput({tag, "_latency"}, 32'(k), 32'(refLatency(ref_a, ref_b)));
            checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            checkOutput({tag, "_gtf"}, 32'(gtf), 32'(ref_a > ref_b));
            checkOutput({tag, "_eqf"}, 32'(eqf), 32'(ref_a == ref_b));
            checkOutput({tag, "_ltf"}, 32'(ltf), 32'(ref_a < ref_b));
            checkOutput({tag, "_onehot"}, 32'(gtf) + 32'(eqf) + 32'(ltf), 32'd1);
        end
    endtask

    // One cycle after done: the pulse has ended and the flags are held.
    task automatic checkHold(input string tag);
        tick();
        checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_flags_hold"}, 32'({gtf, eqf, ltf}),
                    32'({ref_a > ref_b, ref_a == ref_b, ref_a < ref_b}));
    endtask

    // Directed scenarios first, then randomized compares.
    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] one;
        checks   = 0;
        failures = 0;
        one      = 1;

        // Hold reset with start asserted: nothing may start.
        rst_n = 1'b0;
        start = 1'b1;
        i0    = 8'hA5;
        i1    = 8'h25;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_flags", 32'({gtf, eqf, ltf}), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        // MSB decides immediately.
        applyStimulus(8'hA5, 8'h25);
        waitDone("a5_25", 1'b0);
        checkHold("a5_25");

        // Equal operands take the full width.
        applyStimulus(8'h3C, 8'h3C);
        waitDone("3c_3c", 1'b0);
        checkHold("3c_3c");

        // LSB decides.
        applyStimulus(8'h10, 8'h11);
        waitDone("10_11", 1'b0);
        checkHold("10_11");

        // A start and an operand change while busy are ignored. Then a
        // start in the done cycle is accepted.
        applyStimulus(8'h40, 8'h20);
        tick();
        checkOutput("ign_busy_e1", 32'(busy), 32'd1);
        i0    = 8'h00;
        start = 1'b1;
        tick();
        checkOutput("ign_done_e2", 32'(done), 32'd1);
        checkOutput("ign_gtf", 32'(gtf), 32'd1);
        checkOutput("ign_busy_e2", 32'(busy), 32'd0);
        applyStimulus(8'h01, 8'h02);
        waitDone("b2b_01_02", 1'b0);
        checkHold("b2b_01_02");

        // A reset in mid-compare discards the compare with no done pulse.
        applyStimulus(8'h3C, 8'h3C);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_flags", 32'({gtf, eqf, ltf}), 32'd0);
        for (int c = 0; c < W + 2; c++) begin
            tick();
            checkOutput("midrst_no_done", 32'(done), 32'd0);
        end
        applyStimulus(8'hFF, 8'hFE);
        waitDone("ff_fe", 1'b0);
        checkHold("ff_fe");

        // Randomized operands, with the equal and single-bit-different cases
        // weighted in. Noise is driven while busy, and back-to-back starts
        // are mixed in.
        for (int n = 0; n < 60; n++) begin
            x = W'($urandom);
            case ($urandom_range(0, 2))
                0:       y = W'($urandom);
                1:       y = x;
                default: y = x ^ (one << $urandom_range(0, W - 1));
            endcase
            applyStimulus(x, y);
            waitDone("rand", n[0]);
            if ($urandom_range(0, 1) == 1) checkHold("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
